// File: rtl/exec_unit.sv
// exec_unit: single-issue execution unit with registered writeback and flags.
// ALU ops complete one cycle after acceptance; the optional MUL op is an
// 8-iteration shift-add. Build macro EXEC_MUL_EN enables the multiplier; when
// undefined, op=111 completes as a no-writeback operation in one cycle.
module exec_unit #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          areset,
    input  logic          start,
    input  logic [2:0]    op,
    input  logic [2:0]    rd,
    input  logic [DW-1:0] opa,
    input  logic [DW-1:0] opb,
    output logic          busy,
    output logic          done,
    output logic          we,
    output logic [2:0]    waddr,
    output logic [DW-1:0] wdata,
    output logic [2:0]    flags
);

    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_MUL
    } op_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC
`ifdef EXEC_MUL_EN
        , MUL
`endif
    } state_t;

    state_t        state_q, state_d;
    op_t           op_q, op_d;
    logic [2:0]    rd_q, rd_d;
    logic [DW-1:0] a_q, a_d, b_q, b_d;
    logic          busy_q, busy_d, done_q, done_d, we_q, we_d;
    logic [2:0]    waddr_q, waddr_d, flags_q, flags_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW:0]   res;
    logic          wb_en;

`ifdef EXEC_MUL_EN
    localparam int CW = $clog2(DW + 1);
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*DW-1:0] acc_q, acc_d;
`endif

    // ALU: DW+1-bit result, top bit is the carry/borrow/shifted-out bit
    always_comb begin
        res = '0;
        case (op_q)
            OP_ADD:  res = {1'b0, a_q} + {1'b0, b_q};
            OP_SUB:  res = {1'b0, a_q} - {1'b0, b_q};
            OP_AND:  res = {1'b0, a_q & b_q};
            OP_OR:   res = {1'b0, a_q | b_q};
            OP_XOR:  res = {1'b0, a_q ^ b_q};
            OP_SHL:  res = {a_q, 1'b0};
            OP_SHR:  res = {a_q[0], 1'b0, a_q[DW-1:1]};
            default: res = '0;
        endcase
`ifdef EXEC_MUL_EN
        wb_en = 1'b1;
`else
        wb_en = (op_q != OP_MUL);
`endif
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rd_d    = rd_q;
        a_d     = a_q;
        b_d     = b_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        flags_d = flags_q;
`ifdef EXEC_MUL_EN
        cnt_d   = cnt_q;
        acc_d   = acc_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op_t'(op);
                    rd_d    = rd;
                    a_d     = opa;
                    b_d     = opb;
                    busy_d  = 1'b1;
                    state_d = EXEC;
`ifdef EXEC_MUL_EN
                    if (op_t'(op) == OP_MUL) begin
                        state_d = MUL;
                        cnt_d   = '0;
                        acc_d   = '0;
                    end
`endif
                end
            end
            EXEC: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (wb_en) begin
                    we_d    = 1'b1;
                    waddr_d = rd_q;
                    wdata_d = res[DW-1:0];
                    flags_d = {res[DW-1], res[DW-1:0] == '0, res[DW]};
                end
            end
`ifdef EXEC_MUL_EN
            MUL: begin
                if (cnt_q == CW'(DW)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    we_d    = 1'b1;
                    waddr_d = rd_q;
                    wdata_d = acc_q[DW-1:0];
                    flags_d = {acc_q[DW-1], acc_q[DW-1:0] == '0, |acc_q[2*DW-1:DW]};
                end else begin
                    // b_q is consumed LSB-first by shifting it down each step
                    if (b_q[0]) begin
                        acc_d = acc_q + ({{DW{1'b0}}, a_q} << cnt_q);
                    end
                    b_d   = b_q >> 1;
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, asynchronously cleared
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q <= IDLE;
            op_q    <= OP_ADD;
            rd_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            flags_q <= '0;
`ifdef EXEC_MUL_EN
            cnt_q   <= '0;
            acc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            flags_q <= flags_d;
`ifdef EXEC_MUL_EN
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
`endif
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign we    = we_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;
    assign flags = flags_q;

endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: directed scenarios for exec_unit, checked every cycle against
// a behavioural model plus hand-computed literal expectations.
module tb_exec_unit;

`ifdef EXEC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       areset = 1'b1;
    logic       start = 1'b0;
    logic [2:0] op = '0;
    logic [2:0] rd = '0;
    logic [7:0] opa = '0;
    logic [7:0] opb = '0;
    logic       busy, done, we;
    logic [2:0] waddr, flags;
    logic [7:0] wdata;

    int n_cmp = 0;
    int n_err = 0;
    bit finished = 1'b0;

    exec_unit #(.DW(8)) dut (
        .clk(clk), .areset(areset), .start(start), .op(op), .rd(rd),
        .opa(opa), .opb(opb), .busy(busy), .done(done), .we(we),
        .waddr(waddr), .wdata(wdata), .flags(flags)
    );

    always #5 clk = ~clk;

    // Golden result: {writes, carry, result[7:0]} from plain integer arithmetic
    function automatic logic [9:0] gold(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        int unsigned ua, ub, r;
        bit c, v;
        ua = a; ub = b; r = 0; c = 1'b0; v = 1'b1;
        case (o)
            3'd0: begin r = ua + ub; c = (r > 255); end
            3'd1: begin r = ua - ub; c = (ua < ub); end
            3'd2: r = ua & ub;
            3'd3: r = ua | ub;
            3'd4: r = ua ^ ub;
            3'd5: begin r = ua * 2; c = (r > 255); end
            3'd6: begin r = ua / 2; c = (ua % 2) == 1; end
            default: begin
                if (MUL_EN) begin r = ua * ub; c = (r > 255); end
                else v = 1'b0;
            end
        endcase
        return {v, c, r[7:0]};
    endfunction

    // Model: an accepted op occupies the unit for a fixed number of cycles
    logic       m_busy = 0, m_done = 0, m_we = 0;
    logic [2:0] m_waddr = 0, m_flags = 0;
    logic [7:0] m_wdata = 0;
    int         m_rem = 0;
    logic [2:0] p_op = 0, p_rd = 0;
    logic [7:0] p_a = 0, p_b = 0;
    logic [9:0] g;
    assign g = gold(p_op, p_a, p_b);

    always @(posedge clk or posedge areset) begin
        if (areset) begin
            m_busy <= 0; m_done <= 0; m_we <= 0; m_waddr <= 0;
            m_wdata <= 0; m_flags <= 0; m_rem <= 0;
            p_op <= 0; p_rd <= 0; p_a <= 0; p_b <= 0;
        end else begin
            m_done <= 1'b0;
            m_we   <= 1'b0;
            if (m_rem != 0) begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    if (g[9]) begin
                        m_we    <= 1'b1;
                        m_waddr <= p_rd;
                        m_wdata <= g[7:0];
                        m_flags <= {g[7], g[7:0] == 8'h00, g[8]};
                    end
                end
            end else if (start) begin
                p_op <= op; p_rd <= rd; p_a <= opa; p_b <= opb;
                m_rem  <= (op == 3'd7 && MUL_EN) ? 9 : 1;
                m_busy <= 1'b1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [2:0] r, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        start = 1'b1; op = o; rd = r; opa = a; opb = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int waited);
        for (waited = 1; waited <= budget; waited++) begin
            @(negedge clk);
            if (done) return;
        end
        chk("done_timeout", 0, 1);
    endtask

    initial begin
        fork
            begin : compare
                while (!finished) begin
                    @(negedge clk);
                    n_cmp++;
                    if ({busy, done, we, waddr, wdata, flags} !==
                        {m_busy, m_done, m_we, m_waddr, m_wdata, m_flags}) begin
                        n_err++;
                        $display("FAIL cycle t=%0t: dut busy=%b done=%b we=%b waddr=%0d wdata=%02h flags=%03b, model busy=%b done=%b we=%b waddr=%0d wdata=%02h flags=%03b",
                                 $time, busy, done, we, waddr, wdata, flags,
                                 m_busy, m_done, m_we, m_waddr, m_wdata, m_flags);
                    end
                end
            end
            begin : stimulus
                int w;
                logic [2:0] t_op [3];
                logic [7:0] t_a [3], t_b [3], t_res [3];
                logic [2:0] t_fl [3];
                t_op = '{3'd3, 3'd4, 3'd5};
                t_a  = '{8'h0F, 8'h55, 8'h81};
                t_b  = '{8'hF0, 8'h55, 8'h00};
                t_res = '{8'hFF, 8'h00, 8'h02};
                t_fl = '{3'b100, 3'b010, 3'b001};

                repeat (2) @(negedge clk);
                chk("reset_outputs", int'({busy, done, we, waddr, wdata, flags}), 0);
                areset = 1'b0;

                // ADD F0+20
                issue(3'd0, 3'd3, 8'hF0, 8'h20);
                wait_done(4, w);
                chk("add_latency", w, 1);
                chk("add_we", int'(we), 1);
                chk("add_waddr", int'(waddr), 3);
                chk("add_wdata", int'(wdata), 8'h10);
                chk("add_flags", int'(flags), 3'b001);
                chk("add_busy_in_done", int'(busy), 0);

                // SUB 5-5, then back-to-back SUB 3-5 issued in the done cycle
                issue(3'd1, 3'd1, 8'h05, 8'h05);
                wait_done(4, w);
                chk("sub0_wdata", int'(wdata), 8'h00);
                chk("sub0_flags", int'(flags), 3'b010);
                start = 1'b1; op = 3'd1; rd = 3'd2; opa = 8'h03; opb = 8'h05;
                @(negedge clk);
                start = 1'b0;
                chk("b2b_accepted", int'(busy), 1);
                wait_done(4, w);
                chk("sub1_latency", w, 1);
                chk("sub1_waddr", int'(waddr), 2);
                chk("sub1_wdata", int'(wdata), 8'hFE);
                chk("sub1_flags", int'(flags), 3'b101);

                // OR / XOR / SHL table
                for (int i = 0; i < 3; i++) begin
                    issue(t_op[i], 3'(i), t_a[i], t_b[i]);
                    wait_done(4, w);
                    chk("tbl_wdata", int'(wdata), int'(t_res[i]));
                    chk("tbl_flags", int'(flags), int'(t_fl[i]));
                end

                // SHR with operand changed after acceptance
                issue(3'd6, 3'd4, 8'h81, 8'h00);
                opa = 8'h00;
                wait_done(4, w);
                chk("shr_wdata", int'(wdata), 8'h40);
                chk("shr_flags", int'(flags), 3'b001);

`ifdef EXEC_MUL_EN
                // MUL 12*10 with an ignored start at k+3
                issue(3'd7, 3'd6, 8'h12, 8'h10);
                repeat (2) @(negedge clk);
                start = 1'b1; op = 3'd0; rd = 3'd1; opa = 8'h01; opb = 8'h01;
                @(negedge clk);
                start = 1'b0;
                wait_done(12, w);
                chk("mul_latency", w + 3, 9);
                chk("mul_waddr", int'(waddr), 6);
                chk("mul_wdata", int'(wdata), 8'h20);
                chk("mul_flags", int'(flags), 3'b001);
                @(negedge clk);
                chk("mul_no_queue", int'({busy, done}), 0);
`else
                // op=111 without multiplier: done, no writeback, flags held
                issue(3'd7, 3'd6, 8'h12, 8'h10);
                wait_done(4, w);
                chk("nomul_latency", w, 1);
                chk("nomul_we", int'(we), 0);
                chk("nomul_flags", int'(flags), 3'b001);
`endif

                // Reset mid-operation, then a normal AND
`ifdef EXEC_MUL_EN
                issue(3'd7, 3'd5, 8'h12, 8'h10);
                repeat (4) @(posedge clk);
                #1;
`else
                issue(3'd0, 3'd5, 8'h01, 8'h01);
                #1;
`endif
                areset = 1'b1;
                #1;
                chk("midop_reset_outputs", int'({busy, done, we, waddr, wdata, flags}), 0);
                @(posedge clk);
                @(negedge clk);
                areset = 1'b0;
                issue(3'd2, 3'd7, 8'hAA, 8'h0F);
                wait_done(4, w);
                chk("and_latency", w, 1);
                chk("and_waddr", int'(waddr), 7);
                chk("and_wdata", int'(wdata), 8'h0A);
                chk("and_flags", int'(flags), 3'b000);

                repeat (3) @(negedge clk);
                finished = 1'b1;
            end
        join
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 Parameter: DW, 8, operand/result width; all requirements below are stated for DW=8.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: areset  input  1  reset, asynchronous, active-high.
REQ-004 Port: start  input  1  operation request; sampled only in IDLE.
REQ-005 Port: op  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL.
REQ-006 Port: rd  input  3  destination register index for the result.
REQ-007 Port: opa, opb  input  8 each  operands, driven from the register file read ports rout1/rout2.
REQ-008 Port: busy  output  1  high while state is not IDLE.
REQ-009 Port: done  output  1  one-cycle completion pulse.
REQ-010 Port: we, waddr, wdata  output  1/3/8  writeback to the register file we/waddr/wdata.
REQ-011 Port: flags  output  3  {N, Z, C}, registered.

Function
REQ-012 The FSM SHALL have states IDLE, EXEC and MUL, and all outputs SHALL be registered.
REQ-013 In IDLE with start=1 at edge k, the block SHALL latch op, rd, opa and opb.
- op!=111: next state EXEC.
- op=111: next state MUL, with the iteration counter set to 0.
REQ-014 In EXEC, at edge k+1 the block SHALL:
- set wdata to the result, waddr to rd, and we=done=1;
- return to IDLE.
REQ-015 we and done SHALL be high for exactly one cycle per completed operation and low otherwise.
REQ-016 Arithmetic SHALL be 9-bit internally.
- ADD: C = carry-out.
- SUB (opa-opb): C = borrow, 1 when opa<opb.
- SHL: C = opa[7], zero fill.
- SHR: C = opa[0], zero fill.
- AND/OR/XOR: C = 0.
REQ-017 Z SHALL be 1 iff wdata==0, and N SHALL equal wdata[7].
REQ-018 flags SHALL update only on the edge where done rises; at all other times they hold.
REQ-019 MUL SHALL be an unsigned shift-add over 8 iterations, one bit of opb per edge from k+1 to k+8.
- Completion at edge k+9: wdata = low 8 bits of the product.
- C = 1 iff the high 8 bits are nonzero.
REQ-020 busy SHALL be 1 from edge k until the completion edge, and 0 in the cycle where done=1.
REQ-021 start while busy=1 SHALL be ignored, with no queuing.
REQ-022 start=1 in the done cycle SHALL be accepted, giving back-to-back operations.
REQ-023 Operand changes after edge k SHALL NOT affect the result, because operands are latched.

Reset
REQ-024 areset=1 SHALL immediately force IDLE and clear all outputs:
- busy=0, done=0, we=0, waddr=0, wdata=0, flags=000;
- internal registers also cleared.
REQ-025 Assertion of areset mid-operation SHALL abandon the operation with no writeback.
REQ-026 The first start sampled after reset deassertion SHALL be processed normally.

Configuration
REQ-027 Macro EXEC_MUL_EN SHALL control the MUL operation.
- Defined: MUL SHALL be implemented as in REQ-019.
- Undefined: the MUL state and multiplier logic SHALL be absent, and op=111 SHALL complete through EXEC at edge k+1 with done=1, we=0 and flags unchanged.

Verification
REQ-028 The bench SHALL run these directed scenarios:
- ADD opa=8'hF0, opb=8'h20, rd=3 -> one cycle later: we=1, waddr=3, wdata=8'h10, flags N=0 Z=0 C=1, busy never high in the done cycle.
- SUB opa=8'h05, opb=8'h05 then back-to-back SUB opa=8'h03, opb=8'h05 -> first: wdata=8'h00, Z=1, C=0; second accepted in the done cycle: wdata=8'hFE, N=1, C=1.
- MUL opa=8'h12, opb=8'h10 (EXEC_MUL_EN defined) -> busy for 9 cycles, done at k+9, wdata=8'h20, C=1; start pulsed at k+3 is ignored.
- MUL started, then areset at k+4 -> outputs immediately 0, no we pulse; a subsequent AND 8'hAA,8'h0F -> wdata=8'h0A.
- SHR opa=8'h81 with opa changed to 8'h00 one cycle after start -> wdata=8'h40, C=1.
- EXEC_MUL_EN undefined, op=111 -> done=1 at k+1, we=0, flags unchanged.
